cascaded_counter_ctl: RTL and testbench
=======================================

# cascaded_counter_ctl

Parametrised two-stage cascaded counter with run control. A low stage counts modulo a runtime limit; a high stage advances once per low-stage pass through a runtime tap value. A small run/stop/one-shot FSM gates counting. It serves as the general timebase/prescaler block in place of fixed 4+4-bit counter pairs, with concatenated count and event-pulse outputs.

## Interface
- LO_W, 4, low-stage width (≥1)
- HI_W, 4, high-stage width (≥1)
- clk  in  1  rising-edge clock
- clear_n  in  1  synchronous active-low reset
- start  in  1  begin/resume counting (level sampled each edge)
- stop  in  1  halt counting, hold count
- one_shot  in  1  1: stop at high-stage terminal; 0: free-run with wrap
- lo_max  in  LO_W  low-stage terminal value (counts 0..lo_max)
- tap  in  LO_W  low-stage value that advances high stage
- load  in  1  parallel load strobe (only with SYNC_LOAD_EN)
- load_value  in  LO_W+HI_W  {hi,lo} load value (only with SYNC_LOAD_EN)
- cct_output  out  LO_W+HI_W  {hi,lo}, registered
- tap_pulse  out  1  one-cycle pulse, high stage advanced
- wrap_pulse  out  1  one-cycle pulse, high stage wrapped or one-shot finished
- busy  out  1  state == RUN
- done  out  1  state == DONE

## Operation
- Reset (clear_n=0 at edge): lo=0, hi=0, state IDLE, tap_pulse=wrap_pulse=busy=done=0.
- Priority per edge: clear_n > load > stop > start > count.
- FSM states IDLE, RUN, DONE:
  - IDLE: count held. start → RUN, count retained (resume).
  - RUN: counting. stop → IDLE. One-shot terminal → DONE.
  - DONE: count held at terminal. start → RUN with lo=hi=0. stop → IDLE, count held.
- Low stage (RUN only): lo == lo_max or lo > lo_max → lo=0; else lo+1. lo_max=0 holds lo at 0.
- High stage (RUN only): advances when registered lo == tap (pre-update value). tap > lo_max → high stage never advances.
- Advance in free-run: hi+1 modulo 2^HI_W; at hi=all-ones, hi → 0 and wrap_pulse=1.
- Advance in one-shot at hi=all-ones: hi holds all-ones, lo updates normally that edge, state → DONE, wrap_pulse=1.
- tap_pulse=1 on every advance edge, including terminal/wrap.
- lo_max, tap, one_shot changes mid-run take effect at next edge; no restart.
- stop and start together: stop wins.
- load: lo,hi ← load_value; pulses 0; RUN stays RUN; DONE → IDLE; IDLE stays IDLE.

## Timing
- All outputs registered; no combinational input-to-output path.
- start sampled at edge k: busy=1 after edge k; first count change at edge k+1.
- stop sampled at edge k: count at edge k unchanged, busy=0 after edge k.
- tap_pulse/wrap_pulse valid in the same cycle as the updated hi value on cct_output.
- Free-run high-stage period: (lo_max+1) cycles per advance, when tap ≤ lo_max.
- Reset mid-run: all state to reset values at that edge; no pulse.

## Configuration
- SYNC_LOAD_EN defined: load and load_value ports present, load behaviour as above.
- Undefined: ports absent, no load logic; count changes only by reset, count, or DONE→RUN restart.

## Structure
- Package casc_cnt_pkg: state enum typedef (IDLE, RUN, DONE), default LO_W/HI_W constants.
- One sub-module: casc_cnt_stage, a modulo counter with enable, limit, clear, and load, used for the low stage; high stage uses it with limit all-ones.

## Test plan
- Reset, then start, lo_max=15, tap=7, one_shot=0 → hi goes 0→1 on edge when lo goes 7→8; cct_output=0x18 at that cycle, tap_pulse=1.
- lo_max=3, tap=3, free-run → hi advances every 4 cycles; after 64 cycles hi wraps F→0 with wrap_pulse=1.
- one_shot=1, lo_max=1, tap=0 → after hi reaches F, done=1, busy=0, hi held at F; start → cct_output=0x00, busy=1 next cycle.
- start+stop same edge in IDLE → stays IDLE; stop mid-run at count 0x25 → output holds 0x25; start resumes 0x26.
- tap=9 > lo_max=5 → hi stays 0 indefinitely; lo cycles 0..5.
- SYNC_LOAD_EN: load 0xE7 while RUN, lo_max=15, tap=7 → next edge 0xF8, tap_pulse=1; clear_n=0 mid-run → 0x00, IDLE.

Source files
------------

// File: rtl/casc_cnt_pkg.sv
// Shared types and default widths for the cascaded counter controller.
package casc_cnt_pkg;

    localparam int DEF_LO_W = 4;
    localparam int DEF_HI_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cc_state_t;

endpackage

// File: rtl/casc_cnt_stage.sv
// Modulo counter stage: counts 0..limit and wraps to 0. A count already above
// the limit (limit lowered mid-run) also wraps to 0 on the next enabled edge.
// Priority: clear_n > load > clr > en.
module casc_cnt_stage
    import casc_cnt_pkg::*;
#(
    parameter int W = DEF_LO_W
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] limit,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] cnt
);

    // Count register with synchronous reset, load, restart clear and modulo advance.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt >= limit) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/cascaded_counter_ctl.sv
// Two-stage cascaded counter with run/stop/one-shot control.
// The high stage advances on edges where the registered low count equals tap.
// Optional parallel load is enabled by defining SYNC_LOAD_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | count held; start resumes from the held count
// ST_RUN  | counting; stop halts, one-shot terminal moves to ST_DONE
// ST_DONE | count held at terminal; start restarts from zero
module cascaded_counter_ctl
    import casc_cnt_pkg::*;
#(
    parameter int LO_W = DEF_LO_W,
    parameter int HI_W = DEF_HI_W
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 one_shot,
    input  logic [LO_W-1:0]      lo_max,
    input  logic [LO_W-1:0]      tap,
`ifdef SYNC_LOAD_EN
    input  logic                 load,
    input  logic [LO_W+HI_W-1:0] load_value,
`endif
    output logic [LO_W+HI_W-1:0] cct_output,
    output logic                 tap_pulse,
    output logic                 wrap_pulse,
    output logic                 busy,
    output logic                 done
);

    localparam logic [HI_W-1:0] HI_ALL = '1;

    cc_state_t             state_q;
    cc_state_t             state_d;
    logic [LO_W-1:0]       lo;
    logic [HI_W-1:0]       hi;
    logic                  load_eff;
    logic [LO_W+HI_W-1:0]  load_val;
    logic                  count_en;
    logic                  hi_en;
    logic                  restart;
    logic                  tap_d;
    logic                  wrap_d;

`ifdef SYNC_LOAD_EN
    assign load_eff = load;
    assign load_val = load_value;
`else
    assign load_eff = 1'b0;
    assign load_val = '0;
`endif

    // Next state, stage enables and pulse values; load > stop > start > count.
    always_comb begin
        state_d  = state_q;
        count_en = 1'b0;
        hi_en    = 1'b0;
        restart  = 1'b0;
        tap_d    = 1'b0;
        wrap_d   = 1'b0;
        if (load_eff) begin
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end else if (stop) begin
            state_d = ST_IDLE;
        end else if (start && (state_q != ST_RUN)) begin
            restart = (state_q == ST_DONE);
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            count_en = 1'b1;
            if (lo == tap) begin
                tap_d = 1'b1;
                if (hi == HI_ALL) begin
                    wrap_d = 1'b1;
                    // One-shot terminal freezes hi at all-ones; free-run wraps it.
                    if (one_shot) begin
                        state_d = ST_DONE;
                    end else begin
                        hi_en = 1'b1;
                    end
                end else begin
                    hi_en = 1'b1;
                end
            end
        end
    end

    // State register and event pulse registers.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q    <= ST_IDLE;
            tap_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            tap_pulse  <= tap_d;
            wrap_pulse <= wrap_d;
        end
    end

    casc_cnt_stage #(.W(LO_W)) u_lo (
        .clk        (clk),
        .clear_n    (clear_n),
        .clr        (restart),
        .en         (count_en),
        .load       (load_eff),
        .limit      (lo_max),
        .load_value (load_val[LO_W-1:0]),
        .cnt        (lo)
    );

    casc_cnt_stage #(.W(HI_W)) u_hi (
        .clk        (clk),
        .clear_n    (clear_n),
        .clr        (restart),
        .en         (hi_en),
        .load       (load_eff),
        .limit      (HI_ALL),
        .load_value (load_val[LO_W+HI_W-1:LO_W]),
        .cnt        (hi)
    );

    assign cct_output = {hi, lo};
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_cascaded_counter_ctl.sv
// Directed bench for cascaded_counter_ctl with a cycle model feeding a
// scoreboard queue, plus spot checks against fixed expected values.
module tb_cascaded_counter_ctl;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       start;
    logic       stop;
    logic       one_shot;
    logic [3:0] lo_max;
    logic [3:0] tap;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] cct_output;
    logic       tap_pulse;
    logic       wrap_pulse;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [11:0] sb_q[$];

    logic [3:0] m_lo;
    logic [3:0] m_hi;
    int         m_st;
    logic       m_tp;
    logic       m_wp;

    cascaded_counter_ctl #(.LO_W(4), .HI_W(4)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .start      (start),
        .stop       (stop),
        .one_shot   (one_shot),
        .lo_max     (lo_max),
        .tap        (tap),
`ifdef SYNC_LOAD_EN
        .load       (load),
        .load_value (load_value),
`endif
        .cct_output (cct_output),
        .tap_pulse  (tap_pulse),
        .wrap_pulse (wrap_pulse),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model of one clock edge given the currently driven inputs.
    task automatic model_edge();
        logic adv;
        if (!clear_n) begin
            m_lo = 4'd0; m_hi = 4'd0; m_st = 0; m_tp = 1'b0; m_wp = 1'b0;
        end else if (load) begin
            {m_hi, m_lo} = load_value;
            m_tp = 1'b0; m_wp = 1'b0;
            if (m_st == 2) m_st = 0;
        end else if (stop) begin
            m_st = 0; m_tp = 1'b0; m_wp = 1'b0;
        end else if (start && m_st != 1) begin
            if (m_st == 2) begin
                m_lo = 4'd0; m_hi = 4'd0;
            end
            m_st = 1; m_tp = 1'b0; m_wp = 1'b0;
        end else if (m_st == 1) begin
            adv  = (m_lo == tap);
            m_tp = adv;
            m_wp = 1'b0;
            if (adv) begin
                if (m_hi == 4'hF) begin
                    m_wp = 1'b1;
                    if (one_shot) m_st = 2;
                    else m_hi = 4'd0;
                end else begin
                    m_hi = m_hi + 4'd1;
                end
            end
            m_lo = (m_lo >= lo_max) ? 4'd0 : m_lo + 4'd1;
        end else begin
            m_tp = 1'b0; m_wp = 1'b0;
        end
    endtask

    task automatic step(input string tag);
        logic [11:0] exp;
        model_edge();
        sb_q.push_back({m_hi, m_lo, m_tp, m_wp, (m_st == 1), (m_st == 2)});
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check(tag, {20'd0, cct_output, tap_pulse, wrap_pulse, busy, done}, {20'd0, exp});
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        clear_n = 1'b0; start = 1'b0; stop = 1'b0; one_shot = 1'b0;
        lo_max = 4'd15; tap = 4'd7; load = 1'b0; load_value = 8'h00;
        m_lo = 4'd0; m_hi = 4'd0; m_st = 0; m_tp = 1'b0; m_wp = 1'b0;

        steps(2, "reset");
        check("reset_cct", cct_output, 8'h00);
        check("reset_busy", busy, 1'b0);

        // first advance when lo goes 7 -> 8
        clear_n = 1'b1; start = 1'b1;
        step("start1");
        check("start1_busy", busy, 1'b1);
        check("start1_cct", cct_output, 8'h00);
        start = 1'b0;
        steps(8, "cnt1");
        check("cnt1_cct", cct_output, 8'h18);
        check("cnt1_tap", tap_pulse, 1'b1);

        // fast free-run wrap of the high stage
        clear_n = 1'b0; step("rst2"); clear_n = 1'b1;
        lo_max = 4'd3; tap = 4'd3; start = 1'b1;
        step("start2"); start = 1'b0;
        steps(63, "run2");
        check("run2_hiF", cct_output[7:4], 4'hF);
        step("wrap2");
        check("wrap2_cct", cct_output, 8'h00);
        check("wrap2_wp", wrap_pulse, 1'b1);

        // one-shot terminal and restart
        clear_n = 1'b0; step("rst3"); clear_n = 1'b1;
        one_shot = 1'b1; lo_max = 4'd1; tap = 4'd0; start = 1'b1;
        step("start3"); start = 1'b0;
        steps(31, "run3");
        check("os_done", done, 1'b1);
        check("os_busy", busy, 1'b0);
        check("os_cct", cct_output, 8'hF1);
        check("os_wp", wrap_pulse, 1'b1);
        steps(5, "hold3");
        check("os_hold", cct_output, 8'hF1);
        start = 1'b1; step("restart3"); start = 1'b0;
        check("restart_cct", cct_output, 8'h00);
        check("restart_busy", busy, 1'b1);
        one_shot = 1'b0;

        // start+stop, stop at 0x25, resume
        clear_n = 1'b0; step("rst4"); clear_n = 1'b1;
        lo_max = 4'd15; tap = 4'd7; start = 1'b1; stop = 1'b1;
        step("startstop");
        check("startstop_busy", busy, 1'b0);
        stop = 1'b0; step("start4"); start = 1'b0;
        steps(37, "run4");
        check("run4_cct", cct_output, 8'h25);
        stop = 1'b1; step("stop4"); stop = 1'b0;
        check("stop4_cct", cct_output, 8'h25);
        check("stop4_busy", busy, 1'b0);
        steps(3, "idle4");
        check("idle4_cct", cct_output, 8'h25);
        start = 1'b1; step("resume4"); start = 1'b0;
        check("resume4_cct", cct_output, 8'h25);
        step("resume4b");
        check("resume4b_cct", cct_output, 8'h26);

        // lowering lo_max below the current lo wraps lo to 0
        steps(4, "run5");
        lo_max = 4'd3; step("shrink5");
        check("shrink5_lo", cct_output[3:0], 4'h0);
        steps(6, "run5b");

        // tap above lo_max never advances hi
        clear_n = 1'b0; step("rst6"); clear_n = 1'b1;
        lo_max = 4'd5; tap = 4'd9; start = 1'b1;
        step("start6"); start = 1'b0;
        steps(30, "run6");
        check("notap_hi", cct_output[7:4], 4'h0);

`ifdef SYNC_LOAD_EN
        clear_n = 1'b0; step("rst7"); clear_n = 1'b1;
        lo_max = 4'd15; tap = 4'd7; start = 1'b1;
        step("start7"); start = 1'b0;
        steps(3, "run7");
        load = 1'b1; load_value = 8'hE7; step("load7"); load = 1'b0;
        check("load7_cct", cct_output, 8'hE7);
        check("load7_busy", busy, 1'b1);
        step("load7b");
        check("load7b_cct", cct_output, 8'hF8);
        check("load7b_tap", tap_pulse, 1'b1);
`endif

        // reset mid-run
        clear_n = 1'b0; step("rst8"); clear_n = 1'b1;
        lo_max = 4'd15; tap = 4'd2; start = 1'b1;
        step("start8"); start = 1'b0;
        steps(5, "run8");
        clear_n = 1'b0; step("midrst"); clear_n = 1'b1;
        check("midrst_cct", cct_output, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_tap", tap_pulse, 1'b0);
        steps(3, "idle8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
